// File: rtl/weight_update_gated.sv
// Two-stage gated weight update: stage 1 forms saturated lane products step*x >> QP,
// stage 2 adds them into the live weight register with clamping. Load overrides both stages.
module weight_update_gated #(
   parameter int WIDTH = 16,
   parameter int QP    = 12,
   parameter int LEN   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 upd_valid,
   input  logic [WIDTH-1:0]     step_in,
   input  logic [LEN*WIDTH-1:0] vec_packed,
   input  logic [LEN-1:0]       lane_en,
   input  logic                 load_valid,
   input  logic [LEN*WIDTH-1:0] load_packed,
   output logic [LEN*WIDTH-1:0] w_packed,
   output logic                 upd_done,
   output logic                 sat_flag
);

   localparam logic [WIDTH-1:0]   WMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   WMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic [LEN*WIDTH-1:0] p_q, p_d;
   logic [LEN-1:0]       psat_q, psat_d;
   logic [LEN*WIDTH-1:0] w_q, w_d;
   logic [LEN-1:0]       wsat_d;
   logic                 s1_valid_q;
   logic                 done_q;
   logic                 sat_q;

   for (genvar g = 0; g < LEN; g++) begin : g_lane
      logic signed [2*WIDTH-1:0] step_x, x_x, prod, shr;
      logic                      prod_hi, prod_lo;
      logic        [WIDTH-1:0]   w_l, p_l;
      logic        [WIDTH:0]     sum;

      // Operands are sign-extended to the full product width so the multiply is exact.
      assign step_x  = {{WIDTH{step_in[WIDTH-1]}}, step_in};
      assign x_x     = {{WIDTH{vec_packed[g*WIDTH+WIDTH-1]}}, vec_packed[g*WIDTH +: WIDTH]};
      assign prod    = step_x * x_x;
      assign shr     = prod >>> QP;
      assign prod_hi = shr > $signed(PMAX);
      assign prod_lo = shr < $signed(PMIN);

      assign p_d[g*WIDTH +: WIDTH] = !lane_en[g] ? '0 :
                                     prod_hi     ? WMAX :
                                     prod_lo     ? WMIN : shr[WIDTH-1:0];
      assign psat_d[g] = lane_en[g] & (prod_hi | prod_lo);

      assign w_l       = w_q[g*WIDTH +: WIDTH];
      assign p_l       = p_q[g*WIDTH +: WIDTH];
      assign sum       = {w_l[WIDTH-1], w_l} + {p_l[WIDTH-1], p_l};
      assign wsat_d[g] = sum[WIDTH] ^ sum[WIDTH-1];
      assign w_d[g*WIDTH +: WIDTH] = !wsat_d[g] ? sum[WIDTH-1:0] :
                                     sum[WIDTH] ? WMIN : WMAX;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_q        <= '0;
         psat_q     <= '0;
         s1_valid_q <= 1'b0;
         w_q        <= '0;
         done_q     <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         s1_valid_q <= upd_valid & ~load_valid;
         if (upd_valid && !load_valid) begin
            p_q    <= p_d;
            psat_q <= psat_d;
         end
         // Load wins over a stage-2 write landing on the same edge.
         if (load_valid) begin
            w_q    <= load_packed;
            sat_q  <= 1'b0;
            done_q <= 1'b0;
         end else begin
            done_q <= s1_valid_q;
            if (s1_valid_q) begin
               w_q   <= w_d;
               sat_q <= sat_q | (|psat_q) | (|wsat_d);
            end
         end
      end
   end

   assign w_packed = w_q;
   assign upd_done = done_q;
   assign sat_flag = sat_q;

endmodule

// File: tb/tb_weight_update_gated.sv
// Bench for weight_update_gated: table of single updates after a preload, plus
// back-to-back, load collision and asynchronous reset sequences.
module tb_weight_update_gated;

   localparam int WIDTH = 16;
   localparam int QP    = 12;
   localparam int LEN   = 8;
   localparam int W     = LEN*WIDTH + 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 upd_valid = 1'b0;
   logic [WIDTH-1:0]     step_in = '0;
   logic [LEN*WIDTH-1:0] vec_packed = '0;
   logic [LEN-1:0]       lane_en = '0;
   logic                 load_valid = 1'b0;
   logic [LEN*WIDTH-1:0] load_packed = '0;
   logic [LEN*WIDTH-1:0] w_packed;
   logic                 upd_done;
   logic                 sat_flag;

   weight_update_gated #(.WIDTH(WIDTH), .QP(QP), .LEN(LEN)) dut (
      .clk(clk), .reset(reset), .upd_valid(upd_valid), .step_in(step_in),
      .vec_packed(vec_packed), .lane_en(lane_en), .load_valid(load_valid),
      .load_packed(load_packed), .w_packed(w_packed), .upd_done(upd_done),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] w0;
      logic [WIDTH-1:0] step;
      logic [WIDTH-1:0] x;
      logic [LEN-1:0]   en;
      logic [WIDTH-1:0] w_exp;
      logic             sat_exp;
   } vec_t;

   vec_t         vecs[9];
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           failures = 0;
   int           done_cnt = 0;
   int           run_len = 0;
   int           max_run = 0;

   // Scoreboard: every upd_done pops one expected {sat_flag, w_packed}.
   always @(negedge clk) begin
      if (reset && upd_done) begin
         logic [W-1:0] e;
         done_cnt++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_upd_done act=%h req=none", {sat_flag, w_packed});
         end else begin
            e = exp_q.pop_front();
            if ({sat_flag, w_packed} !== e) begin
               failures++;
               $display("FAIL upd_result act=%h req=%h", {sat_flag, w_packed}, e);
            end
         end
      end else begin
         run_len = 0;
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s act=%h req=%h", name, act, req);
      end
   endtask

   function automatic logic [LEN*WIDTH-1:0] rep(input logic [WIDTH-1:0] v);
      logic [LEN*WIDTH-1:0] r;
      for (int i = 0; i < LEN; i++) r[i*WIDTH +: WIDTH] = v;
      return r;
   endfunction

   task automatic drive_load(input logic [WIDTH-1:0] v);
      @(negedge clk);
      load_valid  = 1'b1;
      load_packed = rep(v);
      @(negedge clk);
      load_valid  = 1'b0;
   endtask

   task automatic set_upd(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] x,
                          input logic [LEN-1:0] en);
      upd_valid  = 1'b1;
      step_in    = s;
      vec_packed = rep(x);
      lane_en    = en;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout act=%0d_pending req=0_pending", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [LEN*WIDTH-1:0] ew;

      //          w0       step     x        en     w_exp    sat
      vecs[0] = '{16'h0000, 16'h0800, 16'h1000, 8'hFF, 16'h0800, 1'b0};
      vecs[1] = '{16'h0100, 16'h1000, 16'h0400, 8'h0F, 16'h0500, 1'b0};
      vecs[2] = '{16'h7F00, 16'h1000, 16'h0400, 8'hFF, 16'h7FFF, 1'b1};
      vecs[3] = '{16'h8100, 16'h1000, 16'hFC00, 8'hFF, 16'h8000, 1'b1};
      vecs[4] = '{16'h0000, 16'h7FFF, 16'h7FFF, 8'h01, 16'h7FFF, 1'b1};
      vecs[5] = '{16'h0010, 16'hFFFF, 16'h0001, 8'hAA, 16'h000F, 1'b0};
      vecs[6] = '{16'h0000, 16'h8000, 16'h7FFF, 8'hFF, 16'h8000, 1'b1};
      vecs[7] = '{16'h1234, 16'h7FFF, 16'h7FFF, 8'h00, 16'h0000, 1'b0};
      vecs[8] = '{16'h8000, 16'h8000, 16'h8000, 8'hFF, 16'hFFFF, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset_w", {1'b0, w_packed}, '0);
      chk("reset_done_sat", {{(W-2){1'b0}}, upd_done, sat_flag}, '0);
      reset = 1'b1;

      foreach (vecs[k]) begin
         drive_load(vecs[k].w0);
         for (int i = 0; i < LEN; i++)
            ew[i*WIDTH +: WIDTH] = vecs[k].en[i] ? vecs[k].w_exp : vecs[k].w0;
         d0 = done_cnt;
         @(negedge clk);
         set_upd(vecs[k].step, vecs[k].x, vecs[k].en);
         exp_q.push_back({vecs[k].sat_exp, ew});
         @(negedge clk);
         upd_valid = 1'b0;
         wait_drain($sformatf("vec%0d", k), 6);
         chk($sformatf("vec%0d_done_count", k), W'(done_cnt - d0), W'(1));
      end

      // Four consecutive updates accumulate through the live weight register.
      drive_load(16'h0000);
      max_run = 0;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         set_upd(16'h1000, 16'h0200, 8'hFF);
         exp_q.push_back({1'b0, rep(WIDTH'(j * 16'h0200))});
      end
      @(negedge clk);
      upd_valid = 1'b0;
      wait_drain("b2b", 8);
      chk("b2b_done_run", W'(max_run), W'(4));

      // Set sat_flag, then a load one cycle after an update drops it and clears the flag.
      drive_load(16'h7F00);
      @(negedge clk);
      set_upd(16'h1000, 16'h0400, 8'hFF);
      exp_q.push_back({1'b1, rep(16'h7FFF)});
      @(negedge clk);
      upd_valid = 1'b0;
      wait_drain("sat_pre", 6);
      d0 = done_cnt;
      @(negedge clk);
      set_upd(16'h1000, 16'h0200, 8'hFF);
      @(negedge clk);
      upd_valid   = 1'b0;
      load_valid  = 1'b1;
      load_packed = rep(16'h1234);
      @(negedge clk);
      load_valid  = 1'b0;
      repeat (3) @(negedge clk);
      chk("collide_w_sat", {sat_flag, w_packed}, {1'b0, rep(16'h1234)});
      chk("collide_no_done", W'(done_cnt - d0), '0);

      // Update and load in the same cycle: update discarded.
      d0 = done_cnt;
      @(negedge clk);
      set_upd(16'h1000, 16'h0400, 8'hFF);
      load_valid  = 1'b1;
      load_packed = rep(16'h0042);
      @(negedge clk);
      upd_valid  = 1'b0;
      load_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("same_cycle_w", {sat_flag, w_packed}, {1'b0, rep(16'h0042)});
      chk("same_cycle_no_done", W'(done_cnt - d0), '0);

      // Asynchronous reset between stage 1 and stage 2.
      drive_load(16'h1111);
      d0 = done_cnt;
      @(negedge clk);
      set_upd(16'h1000, 16'h0200, 8'hFF);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      reset     = 1'b0;
      #1;
      chk("async_rst_w", {sat_flag, w_packed}, '0);
      chk("async_rst_done", W'(upd_done), '0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_w", {sat_flag, w_packed}, '0);
      chk("post_rst_no_done", W'(done_cnt - d0), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_update_gated.md
# weight_update_gated

Pipelined LMS-style weight update unit for the spline adaptive filter datapath: keeps LEN signed fixed-point weights and, per accepted update, adds the scaled error times the regressor vector, lane by lane. It is the write side of the dot-product path. The dot-product unit reduces the weight and regressor vectors to one scalar. This block expands one scalar step (mu·e) back into a full packed weight vector, which feeds the dot-product vector input. Per-lane enables gate which weights move, matching the lane gating applied on the forward path.

## Interface
- WIDTH, 16, word width of weights, regressor and step (signed, two's complement)
- QP, 12, fractional bits (Q(WIDTH-QP).QP), so 1.0 = 2^QP
- LEN, 8, number of lanes/weights
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low reset (reset = 0 clears all state immediately)
- upd_valid  in  1  update request; accepted every cycle it is high (no backpressure)
- step_in  in  WIDTH  signed scaled error mu·e, sampled with upd_valid
- vec_packed  in  LEN*WIDTH  regressor x; lane i = bits [i*WIDTH +: WIDTH]
- lane_en  in  LEN  per-lane update enable, sampled with upd_valid
- load_valid  in  1  synchronous weight preload
- load_packed  in  LEN*WIDTH  preload values, lane-packed like vec_packed
- w_packed  out  LEN*WIDTH  current weights, registered
- upd_done  out  1  one-cycle pulse when an update has been written to w_packed
- sat_flag  out  1  sticky; set if any lane saturated since reset or last load

## Operation
- Stage 1 (product), on an accepted update:
  - p[i] = (step_in · x[i]) as a 2·WIDTH signed product, arithmetic-shifted right by QP. This rounds toward −inf, by truncation.
  - The result saturates to the WIDTH signed range.
  - p[i] is forced to 0 where lane_en[i] = 0.
  - Stage 1 registers p[], a valid bit, and a per-lane product-saturation bit.
- Stage 2 (accumulate), when the stage-1 valid bit is set:
  - w[i] ← sat(w[i] + p[i]), computed at WIDTH+1 bits and clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Stage 2 always reads the live weight register, so back-to-back updates accumulate correctly with no hazard and no stall.
- sat_flag sets when any enabled lane clamps in stage 1 or stage 2. It stays set until reset or until a load.
- Load:
  - load_valid = 1 writes w ← load_packed at the next edge.
  - The same edge flushes the stage-1 valid bit, so an in-flight update is dropped and upd_done does not pulse for it.
  - The same edge clears sat_flag.
  - An update presented in the same cycle as load_valid is discarded.
- Lanes with lane_en = 0 hold their value exactly, bit for bit.

## Timing
- Reset state: w_packed = 0 for all lanes, upd_done = 0, sat_flag = 0, stage-1 valid = 0.
- Latency:
  - Update accepted at edge N: products are registered at edge N.
  - Weights are written at edge N+1, with upd_done high in the cycle after N+1.
  - Total: 2 cycles from upd_valid to visible w_packed.
- Throughput is one update per cycle. N consecutive upd_valid cycles give N consecutive upd_done pulses.
- Load takes effect at the next edge, and w_packed is visible one cycle after load_valid.
- Simultaneous events:
  - If load_valid and a stage-2 write coincide, the load wins.
  - If load_valid and upd_valid coincide, the update is dropped.
- Reset asserted mid-pipeline clears everything asynchronously. No partial update survives.
- After reset is released, the first edge may accept upd_valid.

## Test plan
All values below use WIDTH=16, QP=12, LEN=8.
1. Reset, then upd_valid for one cycle with step_in=0x0800 (0.5), all x[i]=0x1000 (1.0), lane_en=0xFF → after 2 cycles all w[i]=0x0800 and upd_done pulses once.
2. Lane gating: preload all w=0x0100, then update with step_in=0x1000, x[i]=0x0400, lane_en=0x0F → lanes 0–3 become 0x0500 and lanes 4–7 stay 0x0100.
3. Back-to-back: 4 consecutive updates with step_in=0x1000, x=0x0200 → w steps through 0x0200, 0x0400, 0x0600, 0x0800 on consecutive cycles, with upd_done high for 4 cycles.
4. Saturation: preload w=0x7F00, then update with step_in=0x1000, x=0x0400 → w=0x7FFF and sat_flag=1. Repeat with negatives (w=0x8100, x=0xFC00) → w=0x8000.
5. Load collision: update at cycle N with load_valid=1, load_packed=0x1234 at cycle N+1 → w=0x1234, no upd_done pulse, sat_flag cleared.
6. Async reset asserted between stage 1 and stage 2 of an update → w=0 immediately, no upd_done pulse after release.
